// File: rtl/pe_imem_loader_if.sv
// pe_imem_loader_if: host stream, control/status and imem port A bundle.
// master = loader side, slave = host/memory side.
`ifndef DEF_PE_INS_WIDTH
`define DEF_PE_INS_WIDTH 27
`endif

interface pe_imem_loader_if #(
    parameter int DATA_WIDTH = `DEF_PE_INS_WIDTH + 5,
    parameter int ADDR_WIDTH = 13
);
    logic                  iStart;
    logic [ADDR_WIDTH-1:0] iBase_Addr;
    logic [ADDR_WIDTH:0]   iWord_Count;
    logic                  iWr_Valid;
    logic [DATA_WIDTH-1:0] iWr_Data;
    logic                  oWr_Ready;
    logic                  oBus_Valid;
    logic [ADDR_WIDTH-1:0] oBus_Address;
    logic [DATA_WIDTH-1:0] oBus_Write_Data;
    logic                  oBus_Write_Enable;
    logic [DATA_WIDTH-1:0] iBus_Read_Data;
    logic                  oBusy;
    logic                  oDone;
    logic [DATA_WIDTH-1:0] oChecksum;
    logic                  oError;

    modport master (
        input  iStart, iBase_Addr, iWord_Count,
        input  iWr_Valid, iWr_Data, iBus_Read_Data,
        output oWr_Ready, oBus_Valid, oBus_Address,
        output oBus_Write_Data, oBus_Write_Enable,
        output oBusy, oDone, oChecksum, oError
    );

    modport slave (
        output iStart, iBase_Addr, iWord_Count,
        output iWr_Valid, iWr_Data, iBus_Read_Data,
        input  oWr_Ready, oBus_Valid, oBus_Address,
        input  oBus_Write_Data, oBus_Write_Enable,
        input  oBusy, oDone, oChecksum, oError
    );
endinterface

// File: rtl/pe_imem_loader.sv
// pe_imem_loader: streams host words into PE imem port A with XOR checksum.
// Define PE_IMEM_LOADER_VERIFY_EN to add readback checksum verification.
`ifndef DEF_PE_INS_WIDTH
`define DEF_PE_INS_WIDTH 27
`endif

module pe_imem_loader #(
    parameter int DATA_WIDTH = `DEF_PE_INS_WIDTH + 5,
    parameter int ADDR_WIDTH = 13
) (
    input logic              iClk,
    input logic              iReset,
    pe_imem_loader_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, VERIFY, DRAIN, DONE
    } state_t;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [ADDR_WIDTH:0]   idx_q, idx_d;
    logic                  bvld_q, bvld_d;
    logic                  bwe_q, bwe_d;
    logic [ADDR_WIDTH-1:0] badr_q, badr_d;
    logic [DATA_WIDTH-1:0] bdat_q, bdat_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic                  done_q, done_d;
    logic                  hs;
    logic                  at_last;
    logic [ADDR_WIDTH-1:0] cur_addr;

`ifdef PE_IMEM_LOADER_VERIFY_EN
    logic [DATA_WIDTH-1:0] vsum_q, vsum_d;
    logic                  rtag_q, rtag_d;
    logic                  rpend_q;
    logic                  rlast_q;
    logic                  err_q, err_d;
`endif

    assign hs       = (state_q == LOAD) && bus.iWr_Valid;
    assign at_last  = (idx_q == cnt_q - CNT_ONE);
    assign cur_addr = base_q + idx_q[ADDR_WIDTH-1:0];

    // State register.
    always_ff @(posedge iClk) begin
        if (iReset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.iStart)
                    state_d = (bus.iWord_Count == '0) ? DONE : LOAD;
            end
            LOAD: begin
`ifdef PE_IMEM_LOADER_VERIFY_EN
                if (hs && at_last) state_d = VERIFY;
`else
                if (hs && at_last) state_d = DONE;
`endif
            end
`ifdef PE_IMEM_LOADER_VERIFY_EN
            VERIFY: if (at_last) state_d = DRAIN;
            DRAIN:  state_d = DONE;
`endif
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; bus strobes default low each cycle.
    always_comb begin
        base_d = base_q;
        cnt_d  = cnt_q;
        idx_d  = idx_q;
        bvld_d = 1'b0;
        bwe_d  = 1'b0;
        badr_d = badr_q;
        bdat_d = bdat_q;
        csum_d = csum_q;
        done_d = (state_q == DONE);
`ifdef PE_IMEM_LOADER_VERIFY_EN
        vsum_d = vsum_q;
        rtag_d = 1'b0;
        err_d  = err_q;
        // Read data lands one cycle after the read was on the bus.
        if (rpend_q) begin
            vsum_d = vsum_q ^ bus.iBus_Read_Data;
            if (rlast_q) err_d = (vsum_d != csum_q);
        end
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.iStart) begin
                    base_d = bus.iBase_Addr;
                    cnt_d  = bus.iWord_Count;
                    idx_d  = '0;
                    csum_d = '0;
`ifdef PE_IMEM_LOADER_VERIFY_EN
                    vsum_d = '0;
                    err_d  = 1'b0;
`endif
                end
            end
            LOAD: begin
                if (hs) begin
                    bvld_d = 1'b1;
                    bwe_d  = 1'b1;
                    badr_d = cur_addr;
                    bdat_d = bus.iWr_Data;
                    csum_d = csum_q ^ bus.iWr_Data;
                    idx_d  = at_last ? '0 : idx_q + CNT_ONE;
                end
            end
`ifdef PE_IMEM_LOADER_VERIFY_EN
            VERIFY: begin
                bvld_d = 1'b1;
                badr_d = cur_addr;
                idx_d  = idx_q + CNT_ONE;
                rtag_d = at_last;
            end
`endif
            default: ;
        endcase
    end

    // Datapath and registered bus outputs.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            base_q <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            bvld_q <= 1'b0;
            bwe_q  <= 1'b0;
            badr_q <= '0;
            bdat_q <= '0;
            csum_q <= '0;
            done_q <= 1'b0;
        end else begin
            base_q <= base_d;
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            bvld_q <= bvld_d;
            bwe_q  <= bwe_d;
            badr_q <= badr_d;
            bdat_q <= bdat_d;
            csum_q <= csum_d;
            done_q <= done_d;
        end
    end

`ifdef PE_IMEM_LOADER_VERIFY_EN
    // Readback tracking: which bus cycle was a read, and whether it was the last.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            vsum_q  <= '0;
            rtag_q  <= 1'b0;
            rpend_q <= 1'b0;
            rlast_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            vsum_q  <= vsum_d;
            rtag_q  <= rtag_d;
            rpend_q <= bvld_q & ~bwe_q;
            rlast_q <= rtag_q;
            err_q   <= err_d;
        end
    end
    assign bus.oError = err_q;
`else
    assign bus.oError = 1'b0;
`endif

    assign bus.oWr_Ready         = (state_q == LOAD);
    assign bus.oBusy             = (state_q != IDLE);
    assign bus.oDone             = done_q;
    assign bus.oBus_Valid        = bvld_q;
    assign bus.oBus_Address      = badr_q;
    assign bus.oBus_Write_Data   = bdat_q;
    assign bus.oBus_Write_Enable = bwe_q;
    assign bus.oChecksum         = csum_q;
endmodule

// File: tb/tb_pe_imem_loader.sv
// tb_pe_imem_loader: directed vectors for pe_imem_loader with a model imem.
// Works with and without PE_IMEM_LOADER_VERIFY_EN defined.
`timescale 1ns/1ps
`ifndef DEF_PE_INS_WIDTH
`define DEF_PE_INS_WIDTH 27
`endif

module tb_pe_imem_loader;
    localparam int DW = `DEF_PE_INS_WIDTH + 5;
    localparam int AW = 13;
`ifdef PE_IMEM_LOADER_VERIFY_EN
    localparam bit VER = 1'b1;
`else
    localparam bit VER = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_imem_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    pe_imem_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .iClk   (clk),
        .iReset (rst),
        .bus    (bus.master)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Model imem: registered read data, optional single-address corruption.
    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic          corrupt = 1'b0;
    logic [AW-1:0] bad_addr = '0;
    always @(posedge clk) begin
        if (bus.oBus_Valid && bus.oBus_Write_Enable)
            mem[bus.oBus_Address] <= bus.oBus_Write_Data;
        if (bus.oBus_Valid && !bus.oBus_Write_Enable)
            bus.iBus_Read_Data <= mem[bus.oBus_Address] ^
                ((corrupt && bus.oBus_Address == bad_addr) ? DW'(1) : DW'(0));
    end

    // Monitor sampled on the falling edge.
    int            cyc = 0;
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    int            wc[$];
    int            n_rd, n_vld, n_done, done_cyc, start_cyc;
    logic          err_at_done, err_after_start;
    logic [DW-1:0] csum_at_done;
    logic [DW-1:0] words [8];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.oBus_Valid === 1'b1) begin
            n_vld++;
            if (bus.oBus_Write_Enable) begin
                wa.push_back(bus.oBus_Address);
                wd.push_back(bus.oBus_Write_Data);
                wc.push_back(cyc);
            end else begin
                n_rd++;
            end
        end
        if (bus.oDone === 1'b1) begin
            n_done++;
            done_cyc     = cyc;
            err_at_done  = bus.oError;
            csum_at_done = bus.oChecksum;
        end
    end

    task automatic run_job(input logic [AW-1:0] base, input int n,
                           input int stall_at, input int stall_len,
                           input bit poke);
        int k, st, guard;
        bit hs;
        wa.delete(); wd.delete(); wc.delete();
        n_rd = 0; n_vld = 0; n_done = 0; done_cyc = -1;
        @(posedge clk); #1;
        bus.iStart      = 1'b1;
        bus.iBase_Addr  = base;
        bus.iWord_Count = n[AW:0];
        start_cyc       = cyc;
        @(posedge clk); #1;
        bus.iStart      = 1'b0;
        err_after_start = bus.oError;
        k = 0; st = 0; guard = 0;
        while (k < n && guard < 200) begin
            bus.iStart = 1'b0;
            if (k == stall_at && st < stall_len) begin
                bus.iWr_Valid = 1'b0;
                st++;
                if (poke && st == 2) bus.iStart = 1'b1;
            end else begin
                bus.iWr_Valid = 1'b1;
                bus.iWr_Data  = words[k];
            end
            hs = bus.iWr_Valid && bus.oWr_Ready;
            @(posedge clk); #1;
            if (hs) k++;
            guard++;
        end
        bus.iWr_Valid = 1'b0;
        bus.iStart    = 1'b0;
        check("handshakes", 64'(k), 64'(n));
        guard = 0;
        while (n_done == 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        check("done_pulses", 64'(n_done), 64'd1);
    endtask

    logic [AW-1:0] exp_a [4];

    initial begin
        rst             = 1'b1;
        bus.iStart      = 1'b0;
        bus.iBase_Addr  = '0;
        bus.iWord_Count = '0;
        bus.iWr_Valid   = 1'b0;
        bus.iWr_Data    = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",  64'(bus.oBusy), 64'd0);
        check("rst_valid", 64'(bus.oBus_Valid), 64'd0);
        check("rst_ready", 64'(bus.oWr_Ready), 64'd0);
        check("rst_done",  64'(bus.oDone), 64'd0);
        check("rst_csum",  64'(bus.oChecksum), 64'd0);
        check("rst_err",   64'(bus.oError), 64'd0);
        rst = 1'b0;

        // Basic 4-word load.
        words[0] = 'h1; words[1] = 'h2; words[2] = 'h4; words[3] = 'h8;
        run_job(13'h010, 4, -1, 0, 1'b0);
        check("t1_nwr", 64'(wa.size()), 64'd4);
        for (int i = 0; i < wa.size() && i < 4; i++) begin
            check("t1_addr", 64'(wa[i]), 64'(13'h010 + i));
            check("t1_data", 64'(wd[i]), 64'(words[i]));
            check("t1_cyc",  64'(wc[i] - start_cyc), 64'(2 + i));
        end
        check("t1_csum", 64'(csum_at_done), 64'hF);
        check("t1_done_lat", 64'(done_cyc - start_cyc), VER ? 64'd11 : 64'd6);
        check("t1_err", 64'(err_at_done), 64'd0);
        check("t1_reads", 64'(n_rd), VER ? 64'd4 : 64'd0);

        // Address wrap.
        words[0] = 'h11; words[1] = 'h22; words[2] = 'h33; words[3] = 'h44;
        exp_a[0] = 13'h1FFE; exp_a[1] = 13'h1FFF;
        exp_a[2] = 13'h0000; exp_a[3] = 13'h0001;
        run_job(13'h1FFE, 4, -1, 0, 1'b0);
        check("t2_nwr", 64'(wa.size()), 64'd4);
        for (int i = 0; i < wa.size() && i < 4; i++)
            check("t2_addr", 64'(wa[i]), 64'(exp_a[i]));
        check("t2_csum", 64'(csum_at_done), 64'h44);

        // Zero-length job.
        run_job(13'h100, 0, -1, 0, 1'b0);
        check("t3_nvld", 64'(n_vld), 64'd0);
        check("t3_done_lat", 64'(done_cyc - start_cyc), 64'd2);
        check("t3_csum", 64'(csum_at_done), 64'd0);

        // Host stall mid-stream, start poked during LOAD.
        words[0] = 'hA; words[1] = 'h5; words[2] = 'hF0;
        run_job(13'h200, 3, 1, 3, 1'b1);
        check("t4_nwr", 64'(wa.size()), 64'd3);
        if (wa.size() == 3) begin
            check("t4_gap",  64'(wc[1] - wc[0]), 64'd4);
            check("t4_next", 64'(wc[2] - wc[1]), 64'd1);
            check("t4_addr2", 64'(wa[2]), 64'h202);
        end
        check("t4_csum", 64'(csum_at_done), 64'hFF);
        check("t4_idle", 64'(bus.oBusy), 64'd0);

        // Readback corruption at base+1.
        words[0] = 'h1; words[1] = 'h2; words[2] = 'h4; words[3] = 'h8;
        corrupt = 1'b1; bad_addr = 13'h021;
        run_job(13'h020, 4, -1, 0, 1'b0);
        check("t5_err", 64'(err_at_done), VER ? 64'd1 : 64'd0);
        check("t5_err_hold", 64'(bus.oError), VER ? 64'd1 : 64'd0);
        check("t5_csum", 64'(csum_at_done), 64'hF);
        corrupt = 1'b0;
        run_job(13'h020, 4, -1, 0, 1'b0);
        check("t5_err_clr", 64'(err_after_start), 64'd0);
        check("t5_err_ok", 64'(err_at_done), 64'd0);

        // Reset in the middle of LOAD.
        @(posedge clk); #1;
        bus.iStart = 1'b1; bus.iBase_Addr = 13'h040; bus.iWord_Count = 14'd5;
        @(posedge clk); #1;
        bus.iStart = 1'b0; bus.iWr_Valid = 1'b1; bus.iWr_Data = 'h3;
        @(posedge clk); #1;
        bus.iWr_Data = 'h5;
        @(posedge clk); #1;
        bus.iWr_Valid = 1'b0; rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_busy",  64'(bus.oBusy), 64'd0);
        check("t6_valid", 64'(bus.oBus_Valid), 64'd0);
        check("t6_ready", 64'(bus.oWr_Ready), 64'd0);
        rst = 1'b0;
        words[0] = 'h3; words[1] = 'h5;
        run_job(13'h040, 2, -1, 0, 1'b0);
        check("t6_nwr", 64'(wa.size()), 64'd2);
        if (wa.size() == 2) check("t6_addr1", 64'(wa[1]), 64'h041);
        check("t6_csum", 64'(csum_at_done), 64'h6);
        check("t6_err", 64'(err_at_done), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pe_imem_loader.md
Name: pe_imem_loader

Overview:
- Bus-side initiator for the PE instruction memory port A (valid / address / write-data / write-enable, registered read data one cycle later).
- Accepts a host stream of instruction words over a valid/ready handshake and writes them to consecutive imem addresses starting at a programmable base.
- Keeps a running XOR checksum of the words written.
- Optionally reads the region back and verifies the checksum before signalling completion.

Parameters:
- DATA_WIDTH, `DEF_PE_INS_WIDTH+5, imem word width (instruction + data select + predication bits).
- ADDR_WIDTH, 13, imem word address width (8K entries).

Ports:
- iClk  in  1  system clock, positive edge.
- iReset  in  1  synchronous, active-high reset.
- iStart  in  1  start pulse; sampled only in IDLE.
- iBase_Addr  in  ADDR_WIDTH  first imem address; captured on start.
- iWord_Count  in  ADDR_WIDTH+1  words to load, 0..8192; captured on start.
- iWr_Valid  in  1  host word valid.
- iWr_Data  in  DATA_WIDTH  host word.
- oWr_Ready  out  1  loader can accept a host word.
- oBus_Valid  out  1  imem port A access valid.
- oBus_Address  out  ADDR_WIDTH  imem port A address.
- oBus_Write_Data  out  DATA_WIDTH  imem port A write data.
- oBus_Write_Enable  out  1  imem port A write enable.
- iBus_Read_Data  in  DATA_WIDTH  imem port A read data, valid one cycle after a read.
- oBusy  out  1  state != IDLE.
- oDone  out  1  one-cycle completion pulse.
- oChecksum  out  DATA_WIDTH  XOR of all words written in the current or last job.
- oError  out  1  verify mismatch; sticky until the next accepted start.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters and checksum 0. Reset mid-job aborts immediately; no further bus accesses are issued.
- States: IDLE, LOAD, VERIFY, DRAIN, DONE.
- IDLE:
  - iStart=1 captures base and count, clears oChecksum and oError.
  - Count != 0: go to LOAD. Count = 0: go straight to DONE with no bus traffic.
- LOAD:
  - oWr_Ready = 1 only in LOAD.
  - Each handshake (iWr_Valid & oWr_Ready) registers a write presented on the next cycle: oBus_Valid=1, oBus_Write_Enable=1, address = base + index (mod 2^ADDR_WIDTH, wraps 8191 -> 0), data = word.
  - oChecksum ^= word on the same edge as the handshake.
  - Host stalls (iWr_Valid=0) insert idle bus cycles (oBus_Valid=0).
  - Last handshake: go to VERIFY if the feature is enabled, else DONE.
- Bus outputs are registered; oBus_Valid drops to 0 the cycle after the final access unless another access follows. oBus_Write_Data is don't-care when write enable is 0.
- VERIFY (feature only):
  - Issues count reads on consecutive cycles, same wrapped addresses, oBus_Write_Enable=0.
  - The first read appears the cycle after the final write, so read-after-write ordering holds.
  - Read data is sampled one cycle after each read is presented and XOR-accumulated into an internal verify checksum.
  - After the last read is issued, go to DRAIN.
- DRAIN: samples the final read word, compares the verify checksum with oChecksum, sets oError on mismatch, then goes to DONE.
- DONE: oDone=1 for exactly one cycle, then IDLE.
- iStart while busy is ignored.
- Latency, no stalls, N words: last write presented N cycles after LOAD entry. oDone follows 1 cycle after the last write (no verify) or N+2 cycles after the last write (verify).

Optional Feature:
- Macro PE_IMEM_LOADER_VERIFY_EN.
- Defined: VERIFY and DRAIN states exist, readback as above, oError is functional.
- Undefined: LOAD goes directly to DONE, iBus_Read_Data is unused, oError is tied 0.

Test Plan:
- Reset then start, base=0x010, count=4, words 0x1,0x2,0x4,0x8, no stalls -> writes at 0x010..0x013 on consecutive cycles, oChecksum=0xF, oDone one pulse; with verify and a model imem, oError=0.
- Base=0x1FFE, count=4 -> write addresses 0x1FFE, 0x1FFF, 0x0000, 0x0001.
- Count=0 -> no oBus_Valid, oDone pulses 2 cycles after start, oChecksum=0.
- Host drops iWr_Valid for 3 cycles mid-stream (count=3) -> exactly 3 writes with a 3-cycle bus gap; iStart pulsed during LOAD is ignored.
- Verify on, model imem corrupts address base+1 on readback (bit flip 0x1) -> oError=1 at oDone; oError clears on the next start.
- iReset asserted in the middle of LOAD (after 2 of 5 words) -> next cycle oBusy=0, oBus_Valid=0, oWr_Ready=0; a fresh start then runs normally.
